// File: rtl/seg7_chan_scan.sv
// rtl/seg7_chan_scan.sv - channel selector/scanner producing registered 7-segment display data
// Optional auto-scan (dwell counter, scan_tick) compiled in by defining SEG7_CHAN_SCAN_AUTOSCAN_EN.
module seg7_chan_scan #(
  parameter int          NCH     = 8,
  parameter int          DW      = 32,
  parameter int          DWELL   = 50000000,
  parameter logic [31:0] RST_PAT = 32'hAA5555AA,
  localparam int         CW      = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DW-1:0]     wr_data,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     sel,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [DW-1:0]     reg_data,
  output logic [DW-1:0]     seg7_data,
  output logic [CW-1:0]     cur_ch,
  output logic              scan_tick,
  output logic              frozen
);

  localparam logic [1:0] M_MAN  = 2'b00;
  localparam logic [1:0] M_AUTO = 2'b01;
  localparam logic [1:0] M_REG  = 2'b10;
  localparam logic [1:0] M_FRZ  = 2'b11;

  logic [DW-1:0] disp0;
  logic [DW-1:0] chan [NCH];
  logic [CW-1:0] disp_sel;
  logic          unused_slice0;

  // Channel 0 comes from the local register; the bus slice 0 is deliberately ignored.
  assign chan[0]       = disp0;
  assign unused_slice0 = ^ch_data[DW-1:0];

  for (genvar i = 1; i < NCH; i++) begin : g_chan
    assign chan[i] = ch_data[i*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp0     <= DW'(RST_PAT);
      seg7_data <= '0;
      frozen    <= 1'b0;
    end else begin
      if (wr_en) disp0 <= wr_data;
      frozen <= (mode == M_FRZ);
      case (mode)
        M_MAN, M_AUTO: seg7_data <= chan[disp_sel];
        M_REG:         seg7_data <= reg_data;
        default:       seg7_data <= seg7_data;
      endcase
    end
  end

`ifdef SEG7_CHAN_SCAN_AUTOSCAN_EN
  localparam int               CNTW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0]  CNT_MAX = CNTW'(DWELL - 1);

  logic [CNTW-1:0] dwell_cnt;
  logic [1:0]      mode_q;
  logic            tick_q;

  assign disp_sel  = (mode == M_AUTO) ? cur_ch : sel;
  assign scan_tick = tick_q;

  // mode_q resets to manual so the first auto-scan edge after reset restarts at sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch    <= '0;
      dwell_cnt <= '0;
      mode_q    <= M_MAN;
      tick_q    <= 1'b0;
    end else begin
      mode_q <= mode;
      tick_q <= 1'b0;
      case (mode)
        M_MAN: begin
          cur_ch    <= sel;
          dwell_cnt <= '0;
        end
        M_AUTO: begin
          if (mode_q != M_AUTO) begin
            cur_ch    <= sel;
            dwell_cnt <= '0;
          end else if (dwell_cnt == CNT_MAX) begin
            dwell_cnt <= '0;
            cur_ch    <= cur_ch + CW'(1);
            tick_q    <= 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt + CNTW'(1);
          end
        end
        default: begin
          cur_ch    <= cur_ch;
          dwell_cnt <= dwell_cnt;
        end
      endcase
    end
  end
`else
  localparam int unused_dwell = DWELL;

  assign disp_sel  = sel;
  assign scan_tick = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch <= '0;
    end else if (mode == M_MAN || mode == M_AUTO) begin
      cur_ch <= sel;
    end
  end
`endif

endmodule

// File: doc/seg7_chan_scan.md
SEG7_CHAN_SCAN -- requirements
Module: seg7_chan_scan

Interface
REQ-001 Parameter NCH, default 8: channel count; power of two, 2..64.
REQ-002 Parameter DW, default 32: data width of every channel and of the output.
REQ-003 Parameter DWELL, default 50000000: clock cycles per channel in auto-scan; at least 1.
REQ-004 Parameter RST_PAT, default 32'hAA5555AA (truncated/zero-extended to DW): reset value of the channel-0 register.
REQ-005 Derived CW = clog2(NCH), the channel-index width.
REQ-006 clk  in  1  the single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 wr_en  in  1  write strobe for the channel-0 register.
REQ-009 wr_data  in  DW  write data for the channel-0 register.
REQ-010 mode  in  2  00 manual, 01 auto-scan, 10 register display, 11 freeze.
REQ-011 sel  in  CW  manual channel select; also the start channel for auto-scan.
REQ-012 ch_data  in  NCH*DW  flat channel bus; slice i is bits [i*DW+DW-1 : i*DW]; slice 0 ignored.
REQ-013 reg_data  in  DW  register-file data shown in register display mode.
REQ-014 seg7_data  out  DW  registered display data.
REQ-015 cur_ch  out  CW  channel currently displayed.
REQ-016 scan_tick  out  1  one-cycle pulse on each auto-scan channel advance.
REQ-017 frozen  out  1  high while mode is 11.

Function
REQ-018 Channel-0 source is the internal register disp0; every other channel i is slice i of ch_data.
REQ-019 disp0 loads wr_data on a clock edge with wr_en=1, in every mode including freeze.
REQ-020 seg7_data is registered and updates one edge after its sources: manual shows channel sel; auto-scan shows channel cur_ch; register mode shows reg_data; freeze holds its value.
REQ-021 A write is therefore visible on seg7_data at the second edge after wr_en, provided channel 0 is displayed.
REQ-022 In manual mode, cur_ch loads sel every edge, the dwell counter is held at 0, and scan_tick=0.
REQ-023 When mode becomes 01 from any other value, on that first edge cur_ch loads sel and the dwell counter clears to 0.
REQ-024 While mode stays 01, the dwell counter increments each edge. At DWELL-1 it wraps to 0, cur_ch increments (NCH-1 wraps to 0) and scan_tick is 1 for that cycle.
REQ-025 With DWELL=1, cur_ch advances and scan_tick is high on every edge while in auto-scan.
REQ-026 In register display mode, cur_ch and the dwell counter hold and scan_tick=0.
REQ-027 In freeze mode, seg7_data, cur_ch and the dwell counter hold, scan_tick=0, and frozen=1 (registered, one edge after entry).
REQ-028 Leaving freeze resumes the entered mode on the next edge. A return to 01 restarts at sel per REQ-023.
REQ-029 The counter width shall hold DWELL-1 without overflow; no other arithmetic wraps except cur_ch.

Reset
REQ-030 With rst=1 on an edge: disp0=RST_PAT, seg7_data=0, cur_ch=0, dwell counter=0, scan_tick=0, frozen=0.
REQ-031 rst overrides wr_en and mode in the same cycle.
REQ-032 Reset mid-scan restarts per REQ-023 on the first non-reset edge with mode=01.

Configuration
REQ-033 Macro SEG7_CHAN_SCAN_AUTOSCAN_EN compiles in auto-scan (dwell counter, scan_tick generation, REQ-023..025).
REQ-034 Without the macro, mode 01 behaves exactly as manual mode 00, scan_tick is tied 0, and no dwell counter exists.

Verification (NCH=8, DW=32, DWELL=4, macro defined unless stated)
REQ-035 Reset, then mode=00, sel=0 -> seg7_data=AA5555AA after one edge; cur_ch=0.
REQ-036 wr_en=1, wr_data=12345678 for one cycle, mode=00, sel=0 -> seg7_data=12345678 at the second edge after wr_en.
REQ-037 ch_data slice 7=DEADBEEF, sel=6, switch mode 00->01 -> cur_ch 6,6,6,6,7,7,7,7,0; scan_tick pulses on the 6->7 and 7->0 edges; seg7_data tracks one edge later.
REQ-038 In mode 01, switch to 11 for 10 cycles with changing ch_data and a wr_en write -> seg7_data and cur_ch constant, frozen=1; return to 10 with reg_data=0000CAFE -> seg7_data=0000CAFE after one edge.
REQ-039 Assert rst for one cycle mid-scan with wr_en=1 -> all outputs per REQ-030, disp0=AA5555AA (write discarded).
REQ-040 Macro undefined, mode=01, sel=3 -> cur_ch stays 3 across 20 edges, scan_tick never asserts.
